// File: rtl/pc_mux_pkg.sv
// Next-PC source encodings shared by the controller and the fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package pc_mux_pkg;

    // Codes 6 and 7 are unused; the selector treats them as sequential fetch.
    typedef enum logic [2:0] {
        PC_NEXT   = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JAL    = 3'd2,
        PC_JALR   = 3'd3,
        PC_MTVEC  = 3'd4,
        PC_MEPC   = 3'd5
    } sel_pc_t;

endpackage : pc_mux_pkg

// File: rtl/type_pkg.sv
// Common scalar types for the RV32I core: address/data words and the reset NOP.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package type_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] data_t;

    // addi x0, x0, 0 -- harmless filler held in the IR until the first real fetch
    localparam data_t NOP_INSN = 32'h0000_0013;

endpackage : type_pkg

// File: rtl/fetch_unit_next_pc_mux.sv
// Combinational next-PC selector with optional misaligned-target redirect (FETCH_MISALIGN_TRAP_EN).
// Latency: zero cycles, purely combinational from every input.
// Backpressure: none; the output is always valid and the consumer decides when to load it.
module next_pc_mux
    import pc_mux_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  sel_pc_t         pc_sel,
    input  logic            taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] next_pc,
    output logic            fetch_misalign
);

    // Masks that clear the low bit (JALR) and the low two bits (trap vector base).
    localparam logic [XLEN-1:0] MASK_BIT0 = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] MASK_LO2  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_plus_imm;
    logic [XLEN-1:0] w_jalr_tgt;
    logic [XLEN-1:0] w_trap_base;
    logic [XLEN-1:0] w_candidate;

    // All adders are XLEN wide so carry-out is dropped and wrap-around is silent.
    assign w_pc_plus4    = pc + FOUR;
    assign w_pc_plus_imm = pc + imm;
    assign w_jalr_tgt    = (rs1 + imm) & MASK_BIT0;
    assign w_trap_base   = mtvec & MASK_LO2;

    // Source select; taken only matters for conditional branches.
    always_comb begin
        w_candidate = w_pc_plus4;
        case (pc_sel)
            PC_NEXT:   w_candidate = w_pc_plus4;
            PC_BRANCH: w_candidate = taken ? w_pc_plus_imm : w_pc_plus4;
            PC_JAL:    w_candidate = w_pc_plus_imm;
            PC_JALR:   w_candidate = w_jalr_tgt;
            PC_MTVEC:  w_candidate = w_trap_base;
            PC_MEPC:   w_candidate = mepc;
            default:   w_candidate = w_pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misalign;

    // A target that is not word aligned is redirected to the trap vector base.
    always_comb begin
        w_misalign = (w_candidate[1:0] != 2'b00);
        next_pc    = w_misalign ? w_trap_base : w_candidate;
    end

    assign fetch_misalign = w_misalign;
`else
    // Misalignment detection disabled: pass the candidate through untouched.
    assign next_pc        = w_candidate;
    assign fetch_misalign = 1'b0;
`endif

endmodule : next_pc_mux

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: requests the word at pc, latches it for execute, and computes next_pc (FETCH_MISALIGN_TRAP_EN adds a misaligned-target trap redirect).
// Latency: icache_valid sampled on an edge gives ir_valid/ir_code right after that edge; 2 cycles per instruction minimum.
// Backpressure: icache_req is held until icache_valid; stall holds the latched instruction in EXEC indefinitely.
module fetch_unit
    import pc_mux_pkg::*;
    import type_pkg::*;
#(
    parameter int                XLEN = 32,
    parameter logic [XLEN-1:0]   NOP  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  sel_pc_t         pc_sel,
    input  logic            taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] ir_code,
    output logic            ir_valid,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] icache_addr,
    output logic            icache_req,
    input  logic [XLEN-1:0] icache_data,
    input  logic            icache_valid,
    output logic            fetch_misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_ir_code;
    logic            w_icache_req;
    logic            w_ir_valid;
    logic            w_ir_load;

    // State register; async reset drops icache_req the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE is a one-cycle post-reset gap, FETCH waits on the cache, EXEC waits on stall.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   w_state_nxt = icache_valid ? EXEC : FETCH;
            EXEC:    w_state_nxt = stall ? EXEC : FETCH;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the current state only.
    always_comb begin
        w_icache_req = 1'b0;
        w_ir_valid   = 1'b0;
        case (r_state)
            FETCH:   w_icache_req = 1'b1;
            EXEC:    w_ir_valid   = 1'b1;
            default: begin
                w_icache_req = 1'b0;
                w_ir_valid   = 1'b0;
            end
        endcase
    end

    // Only a response seen while fetching updates the IR; strays in IDLE/EXEC are dropped.
    assign w_ir_load = (r_state == FETCH) && icache_valid;

    // Instruction register, NOP out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir_code <= NOP;
        end else if (w_ir_load) begin
            r_ir_code <= icache_data;
        end
    end

    assign ir_code     = r_ir_code;
    assign ir_valid    = w_ir_valid;
    assign icache_req  = w_icache_req;
    // Address always follows pc; icache_req alone says whether it means anything.
    assign icache_addr = pc;

    next_pc_mux #(
        .XLEN (XLEN)
    ) u_next_pc_mux (
        .pc             (pc),
        .pc_sel         (pc_sel),
        .taken          (taken),
        .imm            (imm),
        .rs1            (rs1),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .next_pc        (next_pc),
        .fetch_misalign (fetch_misalign)
    );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import pc_mux_pkg::*;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc;
    logic            stall;
    sel_pc_t         pc_sel;
    logic            taken;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] ir_code;
    logic            ir_valid;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] icache_addr;
    logic            icache_req;
    logic [XLEN-1:0] icache_data;
    logic            icache_valid;
    logic            fetch_misalign;

    int n_vec;
    int n_err;

    fetch_unit #(.XLEN(XLEN), .NOP(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .stall          (stall),
        .pc_sel         (pc_sel),
        .taken          (taken),
        .imm            (imm),
        .rs1            (rs1),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .ir_code        (ir_code),
        .ir_valid       (ir_valid),
        .next_pc        (next_pc),
        .icache_addr    (icache_addr),
        .icache_req     (icache_req),
        .icache_data    (icache_data),
        .icache_valid   (icache_valid),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1; pc = 32'h0; stall = 1'b1; pc_sel = PC_NEXT; taken = 1'b0;
        imm = 32'h0; rs1 = 32'h0; mtvec = 32'h0; mepc = 32'h0;
        icache_data = 32'h0050_0093; icache_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (ir_code !== NOP) begin n_err++; $display("FAIL reset_ir_code got=%h exp=%h", ir_code, NOP); end
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
        n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", icache_req); end
        n_vec++; if (next_pc !== 32'h4) begin n_err++; $display("FAIL reset_next_pc got=%h exp=00000004", next_pc); end
    endtask

    task automatic test_zero_wait;
        rst = 1'b0;
        #1;
        n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL idle_req got=%b exp=0", icache_req); end
        @(negedge clk);
        n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL first_req got=%b exp=1", icache_req); end
        n_vec++; if (icache_addr !== 32'h0) begin n_err++; $display("FAIL first_addr got=%h exp=00000000", icache_addr); end
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fetch_ir_valid got=%b exp=0", ir_valid); end
        @(negedge clk);
        n_vec++; if (ir_code !== 32'h0050_0093) begin n_err++; $display("FAIL zw_ir_code got=%h exp=00500093", ir_code); end
        n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL zw_ir_valid got=%b exp=1", ir_valid); end
        n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL exec_req got=%b exp=0", icache_req); end
        // stray response in EXEC must not touch the IR
        icache_data = 32'hDEAD_BEEF;
        @(negedge clk);
        n_vec++; if (ir_code !== 32'h0050_0093) begin n_err++; $display("FAIL exec_stray got=%h exp=00500093", ir_code); end
    endtask

    task automatic test_latency_stall;
        icache_valid = 1'b0; stall = 1'b0; pc = 32'h4;
        @(negedge clk);
        stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL lat_req c=%0d got=%b exp=1", c, icache_req); end
            n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL lat_ir_valid c=%0d got=%b exp=0", c, ir_valid); end
            @(negedge clk);
        end
        n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL lat_req c=2 got=%b exp=1", icache_req); end
        n_vec++; if (icache_addr !== 32'h4) begin n_err++; $display("FAIL lat_addr got=%h exp=00000004", icache_addr); end
        icache_data = 32'h0020_8133; icache_valid = 1'b1;
        @(negedge clk);
        icache_data = 32'h1111_1111;
        for (int c = 0; c < 4; c++) begin
            n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL stall_ir_valid c=%0d got=%b exp=1", c, ir_valid); end
            n_vec++; if (ir_code !== 32'h0020_8133) begin n_err++; $display("FAIL stall_ir_code c=%0d got=%h exp=00208133", c, ir_code); end
            n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL stall_req c=%0d got=%b exp=0", c, icache_req); end
            @(negedge clk);
        end
        stall = 1'b0; icache_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL release_req got=%b exp=1", icache_req); end
    endtask

    task automatic test_reset_mid_fetch;
        // currently in FETCH with no response
        rst = 1'b1;
        #1;
        n_vec++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL midrst_req got=%b exp=0", icache_req); end
        icache_data = 32'hCAFE_F00D; icache_valid = 1'b1;
        @(negedge clk);
        n_vec++; if (ir_code !== NOP) begin n_err++; $display("FAIL midrst_ir_code got=%h exp=%h", ir_code, NOP); end
        rst = 1'b0;
        icache_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (ir_code !== NOP) begin n_err++; $display("FAIL post_rst_ir_code got=%h exp=%h", ir_code, NOP); end
        n_vec++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL post_rst_req got=%b exp=1", icache_req); end
    endtask

    task automatic test_next_pc;
        pc = 32'h100; imm = 32'hFFFF_FFF0; pc_sel = PC_BRANCH; taken = 1'b1; #1;
        n_vec++; if (next_pc !== 32'hF0) begin n_err++; $display("FAIL br_taken got=%h exp=000000f0", next_pc); end
        n_vec++; if (fetch_misalign !== 1'b0) begin n_err++; $display("FAIL br_misalign got=%b exp=0", fetch_misalign); end
        taken = 1'b0; #1;
        n_vec++; if (next_pc !== 32'h104) begin n_err++; $display("FAIL br_not_taken got=%h exp=00000104", next_pc); end
        pc_sel = PC_NEXT; taken = 1'b1; #1;
        n_vec++; if (next_pc !== 32'h104) begin n_err++; $display("FAIL next_ignores_taken got=%h exp=00000104", next_pc); end
        rs1 = 32'h2001; imm = 32'h4; pc_sel = PC_JALR; #1;
        n_vec++; if (next_pc !== 32'h2004) begin n_err++; $display("FAIL jalr got=%h exp=00002004", next_pc); end
        pc = 32'hFFFF_FFFC; imm = 32'h8; pc_sel = PC_JAL; #1;
        n_vec++; if (next_pc !== 32'h4) begin n_err++; $display("FAIL jal_wrap got=%h exp=00000004", next_pc); end
        pc_sel = PC_NEXT; #1;
        n_vec++; if (next_pc !== 32'h0) begin n_err++; $display("FAIL next_wrap got=%h exp=00000000", next_pc); end
        mtvec = 32'h8000_0003; pc_sel = PC_MTVEC; #1;
        n_vec++; if (next_pc !== 32'h8000_0000) begin n_err++; $display("FAIL mtvec got=%h exp=80000000", next_pc); end
        mepc = 32'h1234; pc_sel = PC_MEPC; #1;
        n_vec++; if (next_pc !== 32'h1234) begin n_err++; $display("FAIL mepc got=%h exp=00001234", next_pc); end
        pc = 32'h200; pc_sel = sel_pc_t'(3'd7); #1;
        n_vec++; if (next_pc !== 32'h204) begin n_err++; $display("FAIL code7 got=%h exp=00000204", next_pc); end
        pc_sel = sel_pc_t'(3'd6); #1;
        n_vec++; if (next_pc !== 32'h204) begin n_err++; $display("FAIL code6 got=%h exp=00000204", next_pc); end
    endtask

    task automatic test_misalign;
        pc = 32'h0; imm = 32'h2; mtvec = 32'h8000_0003; pc_sel = PC_JAL; #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_vec++; if (fetch_misalign !== 1'b1) begin n_err++; $display("FAIL misalign_flag got=%b exp=1", fetch_misalign); end
        n_vec++; if (next_pc !== 32'h8000_0000) begin n_err++; $display("FAIL misalign_redirect got=%h exp=80000000", next_pc); end
`else
        n_vec++; if (fetch_misalign !== 1'b0) begin n_err++; $display("FAIL misalign_flag got=%b exp=0", fetch_misalign); end
        n_vec++; if (next_pc !== 32'h2) begin n_err++; $display("FAIL misalign_pass got=%h exp=00000002", next_pc); end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_zero_wait();
        test_latency_stall();
        test_reset_mid_fetch();
        test_next_pc();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the two-stage RV32I core. It issues instruction-cache requests for the current PC and latches the returned instruction word for decode/execute. It also computes the next PC from the PC-select code, the branch outcome, the immediate, rs1, and the trap vectors supplied by the CSR file. The architectural PC register lives in the datapath; this block only reads `pc` and produces `next_pc`.

## Interface
- `XLEN`, 32: data/address width.
- `NOP`, 32'h0000_0013: instruction value held in `ir_code` after reset.
- `clk` input 1: single clock; all state on the rising edge.
- `rst` input 1: one clock; reset is asynchronous and active-high.
- `pc` input XLEN: current PC from the datapath PC register.
- `stall` input 1: controller hold; keeps the latched instruction in EXEC.
- `pc_sel` input 3 (`sel_pc_t`): next-PC source.
- `taken` input 1: branch outcome from decode/execute.
- `imm` input XLEN: sign-extended immediate from decode/execute.
- `rs1` input XLEN: rs1 register value for JALR.
- `mtvec`, `mepc` input XLEN: trap vector and exception PC from the CSR file.
- `ir_code` output XLEN: latched instruction word.
- `ir_valid` output 1: `ir_code` holds the instruction for the current `pc`.
- `next_pc` output XLEN: combinational next PC.
- `icache_addr` output XLEN: fetch address.
- `icache_req` output 1: fetch request.
- `icache_data` input XLEN: returned instruction word.
- `icache_valid` input 1: `icache_data` is valid this cycle.
- `fetch_misalign` output 1: next-PC misalignment flag (see Configuration).

## Operation
- States:
  - IDLE: reset state. `icache_req`=0, `ir_valid`=0. Unconditionally moves to FETCH on the next edge.
  - FETCH: `icache_req`=1, `icache_addr`=`pc`, `ir_valid`=0. On `icache_valid`=1: `ir_code`<=`icache_data` and move to EXEC. Otherwise stay in FETCH. `stall` is ignored in this state.
  - EXEC: `icache_req`=0, `ir_valid`=1. Stay in EXEC while `stall`=1. When `stall`=0, move to FETCH; the controller loads `pc`<=`next_pc` on the same edge.
- `icache_addr` = `pc` in every state. It is qualified only by `icache_req`.
- `next_pc` selection:
  - `PC_NEXT`(0): pc+4.
  - `PC_BRANCH`(1): `taken` ? pc+imm : pc+4.
  - `PC_JAL`(2): pc+imm.
  - `PC_JALR`(3): (rs1+imm) & ~1.
  - `PC_MTVEC`(4): {mtvec[XLEN-1:2], 2'b00}.
  - `PC_MEPC`(5): mepc.
  - Codes 6–7: pc+4.
- All additions are XLEN-bit, modulo 2^XLEN; wrap-around is silent (0xFFFF_FFFC+4 = 0).
- `taken` is ignored unless `pc_sel`=`PC_BRANCH`.

## Timing
- Reset (asynchronous): state IDLE, `ir_code`=NOP, `ir_valid`=0, `icache_req`=0. `next_pc` remains combinational during reset.
- First request: `icache_req` rises one cycle after `rst` deasserts.
- Latency: `icache_valid` sampled at edge N gives `ir_valid`=1 and the new `ir_code` after edge N. The minimum per-instruction period is 2 cycles (FETCH + EXEC) with zero-wait cache.
- `icache_valid` while in IDLE or EXEC is ignored and `ir_code` is unchanged.
- `rst` asserted mid-FETCH drops `icache_req` immediately; a late `icache_valid` after that is ignored.
- `next_pc` is purely combinational, with zero latency from any input.

## Configuration
- Macro `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - `fetch_misalign` = (candidate next_pc[1:0] != 0), combinational.
  - When set, `next_pc` = {mtvec[XLEN-1:2], 2'b00} instead of the candidate.
- Undefined: `fetch_misalign` is tied 0 and the candidate is output unchanged.

## Structure
- Shared package `pc_mux_pkg`: `sel_pc_t` enum and its encodings.
- Shared package `type_pkg`: `addr_t` and `data_t`.
- Local FSM state enum: IDLE, FETCH, EXEC.
- One natural sub-module: `next_pc_mux`, the combinational next-PC selector.

## Test plan
- Reset then zero-wait cache: `pc`=0, `icache_data`=0x00500093 → `icache_req`=1 one cycle after reset release; `ir_code`=0x00500093 and `ir_valid`=1 one cycle later.
- 3-cycle cache latency with `stall`=1 held for 4 cycles in EXEC → `icache_req` stays 1 until `icache_valid`; `ir_valid` stays 1 and `ir_code` is stable for all 4 stall cycles.
- Branch: `pc`=0x100, `imm`=0xFFFF_FFF0, `PC_BRANCH` → `taken`=1 gives `next_pc`=0xF0; `taken`=0 gives 0x104.
- JALR: `rs1`=0x2001, `imm`=4 → `next_pc`=0x2004. JAL from `pc`=0xFFFF_FFFC with `imm`=8 → 0x4 (wrap).
- Trap/return: `mtvec`=0x8000_0003 with `PC_MTVEC` → 0x8000_0000. `mepc`=0x1234 with `PC_MEPC` → 0x1234. Code 7 → pc+4.
- With `FETCH_MISALIGN_TRAP_EN`: `PC_JAL`, `pc`=0, `imm`=2 → `fetch_misalign`=1 and `next_pc` equals the aligned `mtvec`. Without the macro: `fetch_misalign`=0 and `next_pc`=2.
